// File: rtl/osc_freq_monitor.sv
`default_nettype none
// ============================================================================
// osc_freq_monitor - counts clk cycles over REF_EDGES reference periods and
// reports oscillator health (in range / sticky fault / reference lost).
// Revision: 1.0
// ============================================================================
module osc_freq_monitor #(
  parameter int CNT_W       = 16,
  parameter int REF_EDGES   = 4,
  parameter int MIN_COUNT   = 190,
  parameter int MAX_COUNT   = 210,
  parameter int TIMEOUT     = 1024,
  parameter int GOOD_LIMIT  = 2,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ref_in,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             freq_fault,
  output logic             ref_lost
);

  localparam int c_EDGE_W = (REF_EDGES > 1) ? $clog2(REF_EDGES) : 1;
  localparam int c_IDLE_W = $clog2(TIMEOUT + 1);
  localparam int c_GOOD_W = $clog2(GOOD_LIMIT + 1);
  localparam int c_BAD_W  = $clog2(FAULT_LIMIT + 1);

  localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    c_MIN       = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0]    c_MAX       = CNT_W'(MAX_COUNT);
  localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(REF_EDGES - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(TIMEOUT);
  localparam logic [c_IDLE_W-1:0] c_IDLE_HIT  = c_IDLE_W'(TIMEOUT - 1);
  localparam logic [c_GOOD_W-1:0] c_GOOD_MAX  = c_GOOD_W'(GOOD_LIMIT);
  localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(GOOD_LIMIT - 1);
  localparam logic [c_BAD_W-1:0]  c_BAD_MAX   = c_BAD_W'(FAULT_LIMIT);
  localparam logic [c_BAD_W-1:0]  c_BAD_LAST  = c_BAD_W'(FAULT_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_MEASURE = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_ref_meta;
  logic                r_ref_sync;
  logic                r_ref_dly;
  logic [CNT_W-1:0]    r_cnt;
  logic [c_EDGE_W-1:0] r_edges;
  logic [CNT_W-1:0]    r_win_count;
  logic                r_win_sat;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [c_GOOD_W-1:0] r_good_run;
  logic [c_BAD_W-1:0]  r_bad_run;

  logic w_rise;
  logic w_to_hit;
  logic w_timeout;
  logic w_close;
  logic w_check;
  logic w_good;
  logic w_good_event;
  logic w_bad_event;

  assign w_rise       = r_ref_sync & ~r_ref_dly;
  assign w_to_hit     = (r_idle_cnt == c_IDLE_HIT) && !w_rise;
  assign w_check      = en && (r_state == S_CHECK);
  assign w_good       = !r_win_sat && (r_win_count >= c_MIN) && (r_win_count <= c_MAX);
  assign w_good_event = w_check && w_good;
  assign w_bad_event  = (w_check && !w_good) || w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_close      = 1'b0;
    if (!en) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next_state = S_SYNC;
        S_SYNC: begin
          if (w_to_hit)    w_timeout    = 1'b1;
          else if (w_rise) w_next_state = S_MEASURE;
        end
        S_MEASURE: begin
          if (w_to_hit) begin
            w_timeout    = 1'b1;
            w_next_state = S_SYNC;
          end else if (w_rise && (r_edges == c_LAST_EDGE)) begin
            w_close      = 1'b1;
            w_next_state = S_CHECK;
          end
        end
        S_CHECK:   w_next_state = S_MEASURE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Reference synchroniser, no-edge watchdog and window counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_meta  <= 1'b0;
      r_ref_sync  <= 1'b0;
      r_ref_dly   <= 1'b0;
      r_idle_cnt  <= '0;
      r_cnt       <= '0;
      r_edges     <= '0;
      r_win_count <= '0;
      r_win_sat   <= 1'b0;
    end else begin
      r_ref_meta <= ref_in;
      r_ref_sync <= r_ref_meta;
      r_ref_dly  <= r_ref_sync;

      if ((r_state == S_IDLE) || w_rise)  r_idle_cnt <= '0;
      else if (r_idle_cnt != c_IDLE_MAX)  r_idle_cnt <= r_idle_cnt + 1'b1;

      // The closing rise also opens the next window, so the count restarts here
      if (w_close) begin
        r_win_count <= (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + 1'b1;
        r_win_sat   <= (r_cnt == c_CNT_MAX);
        r_cnt       <= '0;
        r_edges     <= '0;
      end else if ((r_state == S_SYNC) && w_rise) begin
        r_cnt   <= '0;
        r_edges <= '0;
      end else if ((r_state == S_MEASURE) || (r_state == S_CHECK)) begin
        if (r_cnt != c_CNT_MAX) r_cnt   <= r_cnt + 1'b1;
        if (w_rise)             r_edges <= r_edges + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_count <= '0;
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      freq_fault <= 1'b0;
      ref_lost   <= 1'b0;
      r_good_run <= '0;
      r_bad_run  <= '0;
    end else begin
      meas_valid <= w_check;
      if (w_check) meas_count <= r_win_count;

      if (!en) begin
        freq_ok    <= 1'b0;
        r_good_run <= '0;
        r_bad_run  <= '0;
      end else if (w_good_event) begin
        r_bad_run <= '0;
        if (r_good_run != c_GOOD_MAX)  r_good_run <= r_good_run + 1'b1;
        if (r_good_run >= c_GOOD_LAST) freq_ok    <= 1'b1;
      end else if (w_bad_event) begin
        freq_ok    <= 1'b0;
        r_good_run <= '0;
        if (r_bad_run != c_BAD_MAX) r_bad_run <= r_bad_run + 1'b1;
      end

      if (w_bad_event && (r_bad_run >= c_BAD_LAST)) freq_fault <= 1'b1;
      else if (clr_fault)                           freq_fault <= 1'b0;

      if (w_timeout)   ref_lost <= 1'b1;
      else if (w_rise) ref_lost <= 1'b0;
    end
  end

endmodule
`default_nettype wire
